// File: rtl/ks_ram_responder.sv
// Memory-side responder for the K&S core: 32 x 16-bit RAM with a byte-serial program loader.
// Optional write protection of the low words is compiled in with `define KS_RAM_WRITE_PROTECT_EN.
module ks_ram_responder #(
  parameter int PROTECT_TOP = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ram_addr,
  input  logic        ram_write_enable,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  output logic        core_hold,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  input  logic        load_last,
  input  logic        load_restart,
  output logic        load_ready,
  output logic        load_done,
  output logic        wr_fault
);

  typedef enum logic [1:0] {
    LOAD_HI = 2'd0,
    LOAD_LO = 2'd1,
    RUN     = 2'd2
  } state_e;

`ifdef KS_RAM_WRITE_PROTECT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif
  localparam logic [5:0] PROT_TOP_W = 6'(PROTECT_TOP);

  state_e      state_q, state_d;
  logic [4:0]  load_addr_q, load_addr_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] data_in_q, data_in_d;
  logic        wr_fault_q, wr_fault_d;

  logic [15:0] mem [0:31];

  logic load_ready_s;
  logic load_fire_s;
  logic load_wr_s;
  logic core_wr_req_s;
  logic prot_hit_s;
  logic core_wr_s;

  // A restart in the same cycle as a byte discards that byte.
  assign load_fire_s   = load_valid && load_ready_s && !load_restart;
  assign load_wr_s     = (state_q == LOAD_LO) && load_fire_s;
  assign core_wr_req_s = (state_q == RUN) && ram_write_enable;
  assign prot_hit_s    = PROT_EN && ({1'b0, ram_addr} < PROT_TOP_W);
  assign core_wr_s     = core_wr_req_s && !prot_hit_s;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_HI;
      load_addr_q <= 5'd0;
      hi_q        <= 8'd0;
      data_in_q   <= 16'd0;
      wr_fault_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_addr_q <= load_addr_d;
      hi_q        <= hi_d;
      data_in_q   <= data_in_d;
      wr_fault_q  <= wr_fault_d;
    end
  end

  // Next-state logic for the loader FSM
  always_comb begin
    state_d     = state_q;
    load_addr_d = load_addr_q;
    hi_d        = hi_q;
    if (load_restart) begin
      state_d     = LOAD_HI;
      load_addr_d = 5'd0;
    end else begin
      case (state_q)
        LOAD_HI: begin
          if (load_fire_s) begin
            hi_d    = load_byte;
            state_d = LOAD_LO;
          end else begin
            state_d = LOAD_HI;
          end
        end
        LOAD_LO: begin
          if (load_fire_s) begin
            if (load_last || (load_addr_q == 5'd31)) begin
              state_d = RUN;
            end else begin
              load_addr_d = load_addr_q + 5'd1;
              state_d     = LOAD_HI;
            end
          end else begin
            state_d = LOAD_LO;
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d     = LOAD_HI;
          load_addr_d = 5'd0;
        end
      endcase
    end
  end

  // Read data is zero outside RUN, including the cycle a restart is taken
  always_comb begin
    data_in_d  = 16'd0;
    wr_fault_d = core_wr_req_s && prot_hit_s;
    if ((state_q == RUN) && !load_restart) begin
      data_in_d = mem[ram_addr];
    end else begin
      data_in_d = 16'd0;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    load_ready_s = 1'b1;
    core_hold    = 1'b1;
    load_done    = 1'b0;
    case (state_q)
      RUN: begin
        load_ready_s = 1'b0;
        core_hold    = 1'b0;
        load_done    = 1'b1;
      end
      default: begin
        load_ready_s = 1'b1;
        core_hold    = 1'b1;
        load_done    = 1'b0;
      end
    endcase
  end

  // Single write port shared by loader and core; the states are exclusive
  always_ff @(posedge clk) begin
    if (load_wr_s) begin
      mem[load_addr_q] <= {hi_q, load_byte};
    end else if (core_wr_s) begin
      mem[ram_addr] <= data_out;
    end
  end

  assign load_ready = load_ready_s;
  assign data_in    = data_in_q;
  assign wr_fault   = wr_fault_q;

endmodule
